// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: masks and prioritises device requests,
// raises one IRQ to the core and tracks the in-service source until EOI.
module int_ctrl #(
   parameter int unsigned     BITS = 32,
   parameter int unsigned     NSRC = 4,
   parameter int unsigned     IDW  = 4,
   parameter logic [BITS-1:0] BASE = 32'hFFFFF100
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [BITS-1:0] ABUS,
   inout  wire  [BITS-1:0] DBUS,
   input  logic            WE,
   input  logic [NSRC-1:0] SRC_INTR,
   input  logic            INTA,
   output logic            IRQ,
   output logic [IDW-1:0]  IID
);

   localparam logic [BITS-1:0] A_ICTRL  = BASE;
   localparam logic [BITS-1:0] A_IMASK  = BASE + BITS'(4);
   localparam logic [BITS-1:0] A_IPEND  = BASE + BITS'(8);
   localparam logic [BITS-1:0] A_ICAUSE = BASE + BITS'(12);
   localparam logic [BITS-1:0] A_IEOI   = BASE + BITS'(16);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERV} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_gie;
   logic              r_spur;
   logic [NSRC-1:0]   r_mask;
   logic [IDW-1:0]    r_cur_id;
   logic [IDW-1:0]    w_cur_id_nxt;
   logic              w_spur_set;
   logic              w_irq_nxt;
   logic [IDW-1:0]    w_iid_nxt;
   logic [NSRC-1:0]   w_pend;
   logic [IDW-1:0]    w_sel;
   logic              w_cur_pend;
   logic              w_wr_ictrl;
   logic              w_wr_imask;
   logic              w_wr_eoi;
   logic              w_rd_en;
   logic [BITS-1:0]   w_rdata;
   logic              w_unused_dbus;

   assign w_pend        = SRC_INTR & r_mask;
   assign w_wr_ictrl    = WE && (ABUS == A_ICTRL);
   assign w_wr_imask    = WE && (ABUS == A_IMASK);
   assign w_wr_eoi      = WE && (ABUS == A_IEOI);
   assign w_unused_dbus = ^DBUS;

   // Fixed priority: lowest pending index wins.
   always_comb begin
      w_sel = '0;
      for (int i = int'(NSRC) - 1; i >= 0; i--) begin
         if (w_pend[i]) w_sel = IDW'(i);
      end
   end

   always_comb begin
      w_cur_pend = 1'b0;
      for (int unsigned i = 0; i < NSRC; i++) begin
         if (r_cur_id == IDW'(i)) w_cur_pend = w_pend[i];
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state  <= ST_IDLE;
         r_cur_id <= '0;
         IRQ      <= 1'b0;
         IID      <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cur_id <= w_cur_id_nxt;
         IRQ      <= w_irq_nxt;
         IID      <= w_iid_nxt;
      end
   end

   // INTA outranks both withdrawal conditions; CUR_ID is frozen once latched.
   always_comb begin
      w_state_nxt  = r_state;
      w_cur_id_nxt = r_cur_id;
      w_spur_set   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_gie && (|w_pend)) begin
               w_state_nxt  = ST_REQ;
               w_cur_id_nxt = w_sel;
            end
         end
         ST_REQ: begin
            if (INTA) begin
               w_state_nxt = ST_SERV;
            end else if (!r_gie) begin
               w_state_nxt = ST_IDLE;
            end else if (!w_cur_pend) begin
               w_state_nxt = ST_IDLE;
               w_spur_set  = 1'b1;
            end
         end
         ST_SERV: begin
            if (w_wr_eoi) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_irq_nxt = (w_state_nxt == ST_REQ);
      w_iid_nxt = (w_state_nxt == ST_IDLE) ? '0 : w_cur_id_nxt;
   end

   // A spurious withdrawal in the same cycle as a clear write keeps SPUR set.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_gie  <= 1'b0;
         r_spur <= 1'b0;
         r_mask <= '0;
      end else begin
         if (w_wr_ictrl) r_gie <= DBUS[0];
         if (w_spur_set) begin
            r_spur <= 1'b1;
         end else if (w_wr_ictrl && !DBUS[2]) begin
            r_spur <= 1'b0;
         end
         if (w_wr_imask) r_mask <= DBUS[NSRC-1:0];
      end
   end

   always_comb begin
      w_rd_en = 1'b0;
      w_rdata = '0;
      if (!WE) begin
         unique case (ABUS)
            A_ICTRL: begin
               w_rd_en = 1'b1;
               w_rdata = BITS'({r_spur, (r_state != ST_IDLE), r_gie});
            end
            A_IMASK: begin
               w_rd_en = 1'b1;
               w_rdata = BITS'(r_mask);
            end
            A_IPEND: begin
               w_rd_en = 1'b1;
               w_rdata = BITS'(w_pend);
            end
            A_ICAUSE: begin
               w_rd_en = 1'b1;
               w_rdata[BITS-1] = (r_state != ST_IDLE);
               w_rdata[IDW-1:0] = r_cur_id;
            end
            A_IEOI: begin
               w_rd_en = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign DBUS = w_rd_en ? w_rdata : {BITS{1'bz}};

endmodule

// File: tb/tb_int_ctrl.sv
// Randomised bench for int_ctrl against a rule-level model of the controller.
module tb_int_ctrl;

   localparam logic [31:0] BASE = 32'hFFFFF100;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] ABUS = '0;
   logic        WE = 1'b0;
   logic [3:0]  SRC_INTR = '0;
   logic        INTA = 1'b0;
   logic        IRQ;
   logic [3:0]  IID;
   logic [31:0] tb_wdata = '0;
   wire  [31:0] DBUS_w;

   int n_checks = 0;
   int n_err    = 0;

   assign DBUS_w = WE ? tb_wdata : 32'hzzzz_zzzz;

   for (genvar g = 0; g < 32; g++) begin : g_pu
      pullup pu (DBUS_w[g]);
   end

   int_ctrl dut (
      .CLK(CLK), .RST(RST), .ABUS(ABUS), .DBUS(DBUS_w), .WE(WE),
      .SRC_INTR(SRC_INTR), .INTA(INTA), .IRQ(IRQ), .IID(IID)
   );

   always #5 CLK = ~CLK;

   // Model: requesting / serving flags, latched id, and the software-visible bits.
   logic       m_req = 1'b0, m_serv = 1'b0, m_gie = 1'b0, m_spur = 1'b0;
   logic [3:0] m_mask = '0, m_id = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [3:0] src);
      logic busy;
      busy = m_req | m_serv;
      if (a == BASE)            return {29'b0, m_spur, busy, m_gie};
      if (a == BASE + 32'd4)    return {28'b0, m_mask};
      if (a == BASE + 32'd8)    return {28'b0, src & m_mask};
      if (a == BASE + 32'd12)   return {busy, 27'b0, m_id};
      if (a == BASE + 32'd16)   return 32'h0;
      return 32'hFFFF_FFFF;
   endfunction

   task automatic m_step();
      logic [3:0] pend;
      int         sel;
      logic       spur_set, wr_ictrl, wr_imask, wr_eoi;
      pend     = SRC_INTR & m_mask;
      sel      = -1;
      for (int i = 3; i >= 0; i--) if (pend[i]) sel = i;
      wr_ictrl = WE && (ABUS == BASE);
      wr_imask = WE && (ABUS == BASE + 32'd4);
      wr_eoi   = WE && (ABUS == BASE + 32'd16);
      spur_set = 1'b0;
      if (m_serv) begin
         if (wr_eoi) m_serv = 1'b0;
      end else if (m_req) begin
         if (INTA) begin
            m_req = 1'b0; m_serv = 1'b1;
         end else if (!m_gie) begin
            m_req = 1'b0;
         end else if (!pend[m_id[1:0]] || m_id > 4'd3) begin
            m_req = 1'b0; spur_set = 1'b1;
         end
      end else if (m_gie && sel >= 0) begin
         m_req = 1'b1;
         m_id  = 4'(sel);
      end
      if (wr_ictrl) m_gie = tb_wdata[0];
      if (spur_set) m_spur = 1'b1;
      else if (wr_ictrl && !tb_wdata[2]) m_spur = 1'b0;
      if (wr_imask) m_mask = tb_wdata[3:0];
   endtask

   initial begin
      forever begin
         @(posedge CLK or negedge RST);
         if (!RST) begin
            m_req = 0; m_serv = 0; m_gie = 0; m_spur = 0; m_mask = '0; m_id = '0;
         end else begin
            m_step();
         end
      end
   end

   // Per-cycle output comparison against the model.
   initial begin
      forever begin
         @(posedge CLK);
         #2;
         chk("irq", 32'(IRQ), 32'(m_req));
         if (m_req || m_serv) chk("iid", 32'(IID), 32'(m_id));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      ABUS = a; tb_wdata = d; WE = 1'b1;
      @(negedge CLK);
      WE = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      ABUS = a; WE = 1'b0;
      #1;
      d = DBUS_w;
   endtask

   logic [31:0] rd;
   logic [31:0] addrs [7];

   initial begin
      addrs[0] = BASE;          addrs[1] = BASE + 32'd4;  addrs[2] = BASE + 32'd8;
      addrs[3] = BASE + 32'd12; addrs[4] = BASE + 32'd16; addrs[5] = BASE - 32'd4;
      addrs[6] = BASE + 32'd20;

      // Reset, then idle with every source asserted but nothing enabled.
      SRC_INTR = 4'hF;
      tick(3);
      RST = 1'b1;
      tick(4);
      chk("reset_irq", 32'(IRQ), 32'h0);
      bus_read(BASE, rd);          chk("reset_ictrl", rd, 32'h0);
      bus_read(BASE + 32'd4, rd);  chk("reset_imask", rd, 32'h0);
      bus_read(BASE + 32'd8, rd);  chk("reset_ipend", rd, 32'h0);

      // Basic request / acknowledge / EOI.
      tick(1);
      SRC_INTR = 4'h0;
      bus_write(BASE + 32'd4, 32'h4);
      bus_write(BASE, 32'h1);
      SRC_INTR = 4'b0100;
      tick(1);
      chk("basic_irq", 32'(IRQ), 32'h1);
      chk("basic_iid", 32'(IID), 32'h2);
      INTA = 1'b1; tick(1); INTA = 1'b0;
      chk("basic_irq_ack", 32'(IRQ), 32'h0);
      bus_read(BASE + 32'd12, rd); chk("basic_icause", rd, 32'h8000_0002);
      bus_read(BASE, rd);          chk("basic_busy", rd, 32'h3);
      bus_write(BASE + 32'd16, 32'h0);
      SRC_INTR = 4'h0;
      bus_read(BASE, rd);          chk("basic_eoi_idle", rd, 32'h1);

      // Priority, no preemption, minimum gap after EOI.
      bus_write(BASE + 32'd4, 32'hF);
      SRC_INTR = 4'b1010;
      tick(1);
      chk("prio_iid", 32'(IID), 32'h1);
      SRC_INTR = 4'b1011;
      tick(1);
      chk("nopreempt_iid", 32'(IID), 32'h1);
      INTA = 1'b1; tick(1); INTA = 1'b0;
      bus_write(BASE + 32'd16, 32'h0);
      chk("gap_irq", 32'(IRQ), 32'h0);
      tick(1);
      chk("next_irq", 32'(IRQ), 32'h1);
      chk("next_iid", 32'(IID), 32'h0);
      INTA = 1'b1; tick(1); INTA = 1'b0;
      bus_write(BASE + 32'd16, 32'h0);
      SRC_INTR = 4'h0;
      tick(1);

      // Spurious withdrawal and sticky SPUR handling.
      SRC_INTR = 4'b1000;
      tick(1);
      chk("spur_iid", 32'(IID), 32'h3);
      SRC_INTR = 4'h0;
      tick(1);
      chk("spur_irq", 32'(IRQ), 32'h0);
      bus_read(BASE, rd);          chk("spur_set", rd, 32'h5);
      bus_write(BASE, 32'h5);
      bus_read(BASE, rd);          chk("spur_w1_keep", rd, 32'h5);
      bus_write(BASE, 32'h1);
      bus_read(BASE, rd);          chk("spur_w0_clear", rd, 32'h1);

      // INTA wins over withdrawal; GIE cleared in REQ is not spurious.
      SRC_INTR = 4'b1000;
      tick(1);
      SRC_INTR = 4'h0; INTA = 1'b1;
      tick(1);
      INTA = 1'b0;
      bus_read(BASE, rd);          chk("inta_wins", rd, 32'h3);
      bus_write(BASE + 32'd16, 32'h0);
      SRC_INTR = 4'b1000;
      tick(1);
      bus_write(BASE, 32'h0);
      tick(1);
      chk("gie_off_irq", 32'(IRQ), 32'h0);
      bus_read(BASE, rd);          chk("gie_off_nospur", rd, 32'h0);

      // Asynchronous reset in the middle of service.
      bus_write(BASE, 32'h1);
      tick(1);
      INTA = 1'b1; tick(1); INTA = 1'b0;
      #2 RST = 1'b0;
      #1;
      chk("arst_irq", 32'(IRQ), 32'h0);
      bus_read(BASE, rd);          chk("arst_ictrl", rd, 32'h0);
      bus_read(BASE + 32'd4, rd);  chk("arst_imask", rd, 32'h0);
      bus_read(BASE - 32'd4, rd);  chk("z_below", rd, 32'hFFFF_FFFF);
      bus_read(BASE + 32'd20, rd); chk("z_above", rd, 32'hFFFF_FFFF);
      RST = 1'b1;
      SRC_INTR = 4'h0;
      tick(1);

      // Random traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         int op;
         if ($urandom_range(3) == 0) SRC_INTR = 4'($urandom);
         INTA = m_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         WE = 1'b0;
         op = $urandom_range(9);
         case (op)
            0: begin ABUS = BASE; tb_wdata = $urandom & 32'hFFFF_FFFE;
                     tb_wdata[0] = ($urandom_range(7) != 0); WE = 1'b1; end
            1: begin ABUS = BASE + 32'd4; tb_wdata = $urandom; WE = 1'b1; end
            2, 3: begin
               if (m_serv || $urandom_range(3) == 0) begin
                  ABUS = BASE + 32'd16; tb_wdata = $urandom; WE = 1'b1;
               end
            end
            4, 5, 6: begin
               int k;
               k = $urandom_range(6);
               bus_read(addrs[k], rd);
               chk("rand_read", rd, m_read(addrs[k], SRC_INTR));
            end
            default: ;
         endcase
         if ($urandom_range(499) == 0) begin
            #2 RST = 1'b0;
            #1 chk("rand_arst_irq", 32'(IRQ), 32'h0);
            RST = 1'b1;
         end
         @(negedge CLK);
      end
      WE = 1'b0;
      INTA = 1'b0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
